// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file scheduler: default widths, FSM encoding
// and the hardwired-zero entry index.
package regfile_pkg;

    localparam int AW_DEFAULT = 5;
    localparam int DW_DEFAULT = 32;
    localparam int ZERO_REG   = 0;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin picker; the last_grant history flop lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] winner_oh
);

    always_comb begin
        winner_oh = 2'b00;
        case (req)
            2'b01:   winner_oh = 2'b01;
            2'b10:   winner_oh = 2'b10;
            2'b11:   winner_oh = last_grant ? 2'b01 : 2'b10;
            default: winner_oh = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester scheduler owning every control pin of a 32x32 register file:
// clears the file after reset, then runs one round-robin-arbitrated transaction at a time.
//
//   state | meaning
//   INIT  | writing 0 to entry <counter>, one entry per cycle
//   IDLE  | waiting for a request; arbitrate and register the winner's command
//   ISSUE | rf_en high for one cycle, grant pulse to the winner
//   RESP  | register file read data arriving; capture it for the winner
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = (1 << AW)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          init_done,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  logic [DW-1:0] wdata0,
    input  logic [AW-1:0] raddr0_a,
    input  logic [AW-1:0] raddr0_b,
    output logic          gnt0,
    output logic          rsp0_valid,
    output logic [DW-1:0] rdata0_a,
    output logic [DW-1:0] rdata0_b,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  logic [DW-1:0] wdata1,
    input  logic [AW-1:0] raddr1_a,
    input  logic [AW-1:0] raddr1_b,
    output logic          gnt1,
    output logic          rsp1_valid,
    output logic [DW-1:0] rdata1_a,
    output logic [DW-1:0] rdata1_b,

    output logic          rf_en,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_raddr1,
    output logic [AW-1:0] rf_raddr2,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2
);

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          last_grant_q;
    logic          owner_q;
    logic          init_done_q;
    logic          gnt0_q, gnt1_q;
    logic          rsp0_valid_q, rsp1_valid_q;
    logic [DW-1:0] rdata0_a_q, rdata0_b_q, rdata1_a_q, rdata1_b_q;
    logic          rf_en_q;
    logic [AW-1:0] rf_waddr_q, rf_raddr1_q, rf_raddr2_q;
    logic [DW-1:0] rf_wdata_q;

    logic [1:0]    winner_oh;
    logic          win_idx;
    logic          sel_we;
    logic [AW-1:0] sel_waddr, sel_raddr_a, sel_raddr_b;
    logic [DW-1:0] sel_wdata;
    logic [AW-1:0] cmd_waddr_d;
    logic [DW-1:0] cmd_wdata_d;

    rr_arb2 u_arb (
        .req        ({req1, req0}),
        .last_grant (last_grant_q),
        .winner_oh  (winner_oh)
    );

    // Read-only requests still pulse rf_en, so they are turned into a write of 0 to entry 0.
    always_comb begin
        win_idx     = winner_oh[1];
        sel_we      = win_idx ? we1      : we0;
        sel_waddr   = win_idx ? waddr1   : waddr0;
        sel_wdata   = win_idx ? wdata1   : wdata0;
        sel_raddr_a = win_idx ? raddr1_a : raddr0_a;
        sel_raddr_b = win_idx ? raddr1_b : raddr0_b;
        cmd_waddr_d = sel_we ? sel_waddr : AW'(ZERO_REG);
        cmd_wdata_d = (sel_we && (sel_waddr != AW'(ZERO_REG))) ? sel_wdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            init_done_q  <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rdata0_a_q   <= '0;
            rdata0_b_q   <= '0;
            rdata1_a_q   <= '0;
            rdata1_b_q   <= '0;
            rf_en_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            rf_raddr1_q  <= '0;
            rf_raddr2_q  <= '0;
        end else begin
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rf_en_q      <= 1'b0;
            case (state_q)
                INIT: begin
                    rf_en_q     <= 1'b1;
                    rf_waddr_q  <= cnt_q;
                    rf_wdata_q  <= '0;
                    rf_raddr1_q <= '0;
                    rf_raddr2_q <= '0;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        cnt_q       <= '0;
                        init_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (|winner_oh) begin
                        rf_en_q      <= 1'b1;
                        rf_waddr_q   <= cmd_waddr_d;
                        rf_wdata_q   <= cmd_wdata_d;
                        rf_raddr1_q  <= sel_raddr_a;
                        rf_raddr2_q  <= sel_raddr_b;
                        gnt0_q       <= winner_oh[0];
                        gnt1_q       <= winner_oh[1];
                        last_grant_q <= win_idx;
                        owner_q      <= win_idx;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= RESP;
                end
                RESP: begin
                    if (owner_q) begin
                        rdata1_a_q   <= rf_rdata1;
                        rdata1_b_q   <= rf_rdata2;
                        rsp1_valid_q <= 1'b1;
                    end else begin
                        rdata0_a_q   <= rf_rdata1;
                        rdata0_b_q   <= rf_rdata2;
                        rsp0_valid_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign init_done  = init_done_q;
    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rdata0_a   = rdata0_a_q;
    assign rdata0_b   = rdata0_b_q;
    assign rdata1_a   = rdata1_a_q;
    assign rdata1_b   = rdata1_b_q;
    assign rf_en      = rf_en_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign rf_raddr1  = rf_raddr1_q;
    assign rf_raddr2  = rf_raddr2_q;

endmodule
